// File: rtl/fb_port_arbiter.sv
// Frame-buffer port arbiter: display reads own the RAM during active video, and
// posted drawing writes drain from a FIFO during blanking. Optional stats: FB_ARB_STATS_EN.
module fb_port_arbiter #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned H_DISPLAY  = 256,
  parameter int unsigned V_DISPLAY  = 480,
  localparam int unsigned COL_W     = $clog2(H_DISPLAY),
  localparam int unsigned ROW_W     = $clog2(V_DISPLAY),
  localparam int unsigned ADDR_W    = ROW_W + COL_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              video_on,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              wr_dropped,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       stall_cnt
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN} state_t;

  state_t              state_q, state_d;
  wr_entry_t           fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]    count_q;
  logic [ADDR_W-1:0]   last_addr_q;
  wr_entry_t           head;
  logic                full, empty, push, pop, head_oor, s1_valid;

  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign wr_ready = reset_n && !full;
  assign push     = wr_valid && wr_ready;
  assign pop      = (state_d == ST_DRAIN);
  assign head     = fifo_mem[rd_ptr_q];
  assign head_oor = (32'(head.addr[ADDR_W-1:COL_W]) >= V_DISPLAY);

  // Write FIFO storage; no reset needed since occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= '{addr: wr_addr, data: wr_data};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Owner register; a registered READ doubles as the stage-1 pixel valid.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = ST_IDLE;
    if (!reset_n)      state_d = ST_IDLE;
    else if (video_on) state_d = ST_READ;
    else if (!empty)   state_d = ST_DRAIN;
  end

  // Port-select outputs follow the owner of the current cycle.
  always_comb begin
    mem_addr   = reset_n ? last_addr_q : '0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    wr_dropped = 1'b0;
    case (state_d)
      ST_READ: begin
        mem_addr = {pixel_y[ROW_W-1:0], pixel_x[COL_W-1:0]};
      end
      ST_DRAIN: begin
        mem_addr   = head.addr;
        mem_wdata  = head.data;
        mem_we     = !head_oor;
        wr_dropped = head_oor;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) last_addr_q <= '0;
    else          last_addr_q <= mem_addr;
  end

  assign s1_valid = (state_q == ST_READ);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pix_valid <= 1'b0;
      pix_data  <= '0;
    end else begin
      pix_valid <= s1_valid;
      pix_data  <= s1_valid ? mem_rdata : '0;
    end
  end

`ifdef FB_ARB_STATS_EN
  logic [15:0] frame_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if ((pixel_x == '0) && (pixel_y == '0)) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (wr_valid && !wr_ready && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  assign frame_cnt = '0;
  assign stall_cnt = '0;
`endif

  // Pixel coordinate bits above the frame-buffer range do not take part in addressing.
  logic unused_coord;
  assign unused_coord = ^{pixel_x[9:COL_W], pixel_y[9:ROW_W]};

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Randomized scoreboard bench for fb_port_arbiter: expected RAM writes and pixels are
// queued from stimulus and checked by a negedge monitor against a stub RAM.
module tb_fb_port_arbiter;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        video_on = 1'b0;
  logic [9:0]  pixel_x = '0, pixel_y = '0;
  logic        wr_valid = 1'b0, wr_ready;
  logic [16:0] wr_addr = '0, mem_addr;
  logic [7:0]  wr_data = '0, mem_wdata, mem_rdata = '0, pix_data;
  logic        mem_we, pix_valid, wr_dropped;
  logic [15:0] frame_cnt, stall_cnt;

  fb_port_arbiter dut (
    .clk(clk), .reset_n(reset_n), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pix_data(pix_data), .pix_valid(pix_valid), .wr_dropped(wr_dropped),
    .frame_cnt(frame_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    logic [7:0] data;
    int         due;
  } pix_t;

  wr_t         exp_wr[$];
  pix_t        exp_pix[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [16:0] last_addr = '0;
  logic [7:0]  rd_next = '0;
  int          m_frame = 0;
  int          m_stall = 0;

  // Stub RAM contents: a fixed function of the address.
  function automatic logic [7:0] ram_word(input logic [16:0] a);
    logic [7:0] r;
    r = 8'(a[7:0] * 8'd3) ^ a[16:9] ^ {7'd0, a[8]} ^ 8'hC3;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, want);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // One-cycle RAM read latency: address seen in cycle N, data driven in N+1.
  always @(posedge clk) begin
    #1;
    mem_rdata = rd_next;
  end

  always @(negedge clk) begin
    if (cyc >= 1) begin
      logic exp_v;
      rd_next = ram_word(mem_addr);
      if (!reset_n) begin
        check("rst_we", 32'(mem_we), 0);
        check("rst_ready", 32'(wr_ready), 0);
        check("rst_drop", 32'(wr_dropped), 0);
        check("rst_addr", 32'(mem_addr), 0);
      end else begin
        check("ready", 32'(wr_ready), 32'(exp_wr.size() < DEPTH));
        if (video_on) begin
          logic [16:0] ra;
          ra = {pixel_y[8:0], pixel_x[7:0]};
          check("rd_addr", 32'(mem_addr), 32'(ra));
          check("rd_we", 32'(mem_we), 0);
          check("rd_drop", 32'(wr_dropped), 0);
          exp_pix.push_back('{ram_word(ra), cyc + 2});
          last_addr = ra;
        end else if (exp_wr.size() > 0) begin
          wr_t e;
          logic dropped;
          e = exp_wr.pop_front();
          dropped = (e.addr[16:8] >= 9'd480);
          check("drain_addr", 32'(mem_addr), 32'(e.addr));
          check("drain_we", 32'(mem_we), 32'(!dropped));
          check("drain_drop", 32'(wr_dropped), 32'(dropped));
          if (!dropped) check("drain_data", 32'(mem_wdata), 32'(e.data));
          last_addr = e.addr;
        end else begin
          check("idle_we", 32'(mem_we), 0);
          check("idle_drop", 32'(wr_dropped), 0);
          check("idle_addr", 32'(mem_addr), 32'(last_addr));
        end
        if (wr_valid && wr_ready) exp_wr.push_back('{wr_addr, wr_data});
      end

      exp_v = (exp_pix.size() > 0) && (exp_pix[0].due == cyc);
      check("pix_valid", 32'(pix_valid), 32'(exp_v));
      if (exp_v) begin
        pix_t p;
        p = exp_pix.pop_front();
        if (pix_valid) check("pix_data", 32'(pix_data), 32'(p.data));
      end else begin
        check("pix_zero", 32'(pix_data), 0);
      end

`ifdef FB_ARB_STATS_EN
      check("frame_cnt", 32'(frame_cnt), 32'(m_frame & 16'hFFFF));
      check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      if (!reset_n) begin
        m_frame = 0;
        m_stall = 0;
      end else begin
        if (pixel_x == 10'd0 && pixel_y == 10'd0) m_frame++;
        if (wr_valid && !wr_ready && m_stall < 65535) m_stall++;
      end
`else
      check("frame_cnt_off", 32'(frame_cnt), 0);
      check("stall_cnt_off", 32'(stall_cnt), 0);
`endif

      // Reset loses queued writes and reads still in the pixel pipeline.
      if (!reset_n) begin
        exp_wr.delete();
        last_addr = '0;
        while (exp_pix.size() > 0 && exp_pix[exp_pix.size()-1].due > cyc)
          void'(exp_pix.pop_back());
      end
    end
  end

  function automatic logic [16:0] gen_addr();
    int sel;
    logic [8:0] row;
    sel = $urandom_range(0, 99);
    if (sel < 6)       row = 9'd480;
    else if (sel < 10) row = 9'($urandom_range(481, 511));
    else               row = 9'($urandom_range(0, 479));
    return {row, 8'($urandom_range(0, 255))};
  endfunction

  task automatic step(input bit v, input bit rn, input int wp, input int x, input int y);
    @(posedge clk);
    #1;
    reset_n  = rn;
    video_on = v;
    pixel_x  = 10'(x);
    pixel_y  = 10'(y);
    wr_valid = ($urandom_range(0, 99) < wp);
    wr_addr  = gen_addr();
    wr_data  = 8'($urandom);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    // Directed: fill the FIFO during active video, then drain in blanking.
    for (int i = 0; i < 24; i++) step(1'b1, 1'b1, 100, i, 0);
    for (int i = 0; i < 24; i++) step(1'b0, 1'b1, 0, 300 + i, 0);
    for (int ph = 0; ph < 150; ph++) begin
      int act, blk, wp, y;
      act = $urandom_range(0, 40);
      blk = $urandom_range(1, 24);
      wp  = $urandom_range(0, 100);
      y   = (ph % 4) + (($urandom_range(0, 7) == 0) ? 512 : 0);
      for (int i = 0; i < act; i++) begin
        int x;
        x = i + (($urandom_range(0, 7) == 0) ? 256 * $urandom_range(1, 3) : 0);
        step(1'b1, 1'b1, wp, x, y);
      end
      for (int i = 0; i < blk; i++) step(1'b0, 1'b1, wp, 256 + i, y);
      if ($urandom_range(0, 9) == 0) begin
        int rl;
        rl = $urandom_range(1, 2);
        for (int i = 0; i < rl; i++)
          step(1'(($urandom_range(0, 1))), 1'b0, wp, $urandom_range(0, 1023), y);
      end
    end
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 0, 400, 5);
    @(negedge clk);
    #1;
    check("fifo_drained", 32'(exp_wr.size()), 0);
    check("pix_flushed", 32'(exp_pix.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fb_port_arbiter.md
# fb_port_arbiter

Shares one single-port synchronous frame-buffer RAM between two users:
- the VGA display path, which reads one word per active pixel;
- a drawing engine, which posts pixel writes through a valid/ready handshake.

Posted writes are buffered in an internal FIFO and drained only while the display is blanked, so the scan-out never stalls. The block sits between the VGA timing controller (which supplies `video_on`, `pixel_x`, `pixel_y`) and the frame-buffer RAM, and delivers pixel data aligned to a delayed `video_on`.

## Interface

Parameters:
- `DATA_W`, 8 — frame-buffer word width (one word per pixel).
- `FIFO_DEPTH`, 16 — write FIFO entries; power of two, at least 2.
- `H_DISPLAY`, 256 — active pixels per line; `pixel_x` bits [7:0] address the column.
- `V_DISPLAY`, 480 — active lines; `pixel_y` bits [8:0] address the row.

Ports:
- `clk`  in  1 — single clock, rising edge.
- `reset_n`  in  1 — synchronous, active-low reset.
- `video_on`  in  1 — display-active flag from the timing controller.
- `pixel_x`  in  10 — current column.
- `pixel_y`  in  10 — current row.
- `wr_valid`  in  1 — drawing-engine write request.
- `wr_ready`  out  1 — FIFO can accept a write.
- `wr_addr`  in  17 — {row[8:0], col[7:0]}.
- `wr_data`  in  DATA_W — pixel value.
- `mem_addr`  out  17 — RAM address.
- `mem_we`  out  1 — RAM write enable.
- `mem_wdata`  out  DATA_W — RAM write data.
- `mem_rdata`  in  DATA_W — RAM read data; 1-cycle read latency.
- `pix_data`  out  DATA_W — pixel to the DAC; 0 when not valid.
- `pix_valid`  out  1 — `pix_data` is an active pixel.
- `wr_dropped`  out  1 — one-cycle pulse when a drained write is discarded as out of range.
- `frame_cnt`  out  16 — frames started (stats build only).
- `stall_cnt`  out  16 — cycles with `wr_valid=1` and `wr_ready=0` (stats build only).

## Operation

- Write FIFO:
  - A push occurs when `wr_valid && wr_ready` on a rising edge.
  - `wr_ready` = !full; it is held 0 while `reset_n` is 0.
  - There is no fall-through: an entry pushed in cycle N is poppable at the earliest in cycle N+1.
- Port owner is decided each cycle, in priority order:
  1. `video_on=1`: READ. `mem_addr` = {`pixel_y[8:0]`, `pixel_x[7:0]`}, `mem_we=0`.
  2. `video_on=0` and FIFO non-empty: DRAIN. Pop the head; `mem_addr`/`mem_wdata` = head entry. `mem_we=1` unless the head row is ≥ V_DISPLAY, in which case `mem_we=0` and `wr_dropped` pulses.
  3. Otherwise: IDLE. `mem_we=0`, `mem_addr` holds its last value.
- State register {IDLE, READ, DRAIN} records the owner for the status/debug path. Transitions follow the rule above every cycle, and READ preempts DRAIN immediately.
- A pop happens only in DRAIN, so a simultaneous push and pop is legal and leaves the count unchanged.
- Pixel path:
  - Stage 1 registers `video_on` together with the RAM read.
  - Stage 2 registers `mem_rdata`. The result is `pix_data` = stage-1 valid ? `mem_rdata` : 0.
  - `pix_valid` = `video_on` delayed by 2 cycles.
- Reset (synchronous, applies even mid-drain or mid-line):
  - FIFO is emptied; queued writes are lost.
  - State goes to IDLE.
  - `mem_we`, `mem_addr`, `mem_wdata`, `pix_data`, `pix_valid`, `wr_dropped`, `frame_cnt`, `stall_cnt` are all 0.

## Timing

- Display read latency: an address is presented in cycle N, `mem_rdata` is valid in N+1, and `pix_data`/`pix_valid` are valid in N+2.
- Port-select outputs (`mem_addr`, `mem_we`, `mem_wdata`) are combinational from the state of the current cycle: the `video_on` input and FIFO occupancy.
- Write latency: push in cycle N, RAM write at the earliest in cycle N+1, and only if `video_on=0` in that cycle.
- Drain rate: one write per blank cycle. With H_DISPLAY=256 and 63 horizontal blank cycles, a full 16-entry FIFO empties in one line's blanking.
- `wr_dropped` is asserted in the same cycle as the discarding pop.

## Configuration

- `FB_ARB_STATS_EN`:
  - Defined:
    - `frame_cnt` increments, wrapping at 16 bits, in the cycle where `pixel_x==0 && pixel_y==0`.
    - `stall_cnt` increments, saturating at 0xFFFF, on every cycle with `wr_valid && !wr_ready`.
  - Undefined: both outputs are tied to 0 and no counter flops are built.
  - Arbitration and pixel path are identical in both builds.

## Test plan

- Reset during DRAIN with 5 entries queued → the next cycle has `mem_we=0`, `wr_ready=1`, and no further writes occur after release.
- `video_on=1`, `pixel_x=3`, `pixel_y=2`, RAM returns 0xA5 → `mem_addr`=0x00203; two cycles later `pix_data`=0xA5, `pix_valid=1`.
- Push 16 writes during active video → `wr_ready=0` after the 16th push, no `mem_we` while `video_on=1`, then 16 consecutive `mem_we` cycles in address order once `video_on` falls. Stats build: `stall_cnt` equals the cycles `wr_valid` was held while full.
- `video_on` rises after 3 drain cycles with 5 queued → `mem_we` drops the same cycle, and the remaining 2 writes complete at the next blanking.
- Push to `wr_addr` row 480 (0x1E000) during blanking → `wr_dropped` pulses once, `mem_we=0`, and the FIFO count decrements.
- Stats build, run 3 full frames from reset → `frame_cnt`=3. Non-stats build → `frame_cnt`=0.
